// File: rtl/ex_mem_wb_forward_source.sv
// EX/MEM and MEM/WB pipeline registers that feed forwarding values back to Execute,
// plus load-use hazard detection and a saturating stall-cycle counter.
module ex_mem_wb_forward_source #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic [DATA_W-1:0] EX_ALUResult,
    input  logic [REG_W-1:0]  EX_rDestSelected,
    input  logic              EX_RegWrite,
    input  logic              EX_MemRead,
    input  logic              EX_MemWrite,
    input  logic              EX_MemToReg,
    input  logic [DATA_W-1:0] EX_StoreData,
    input  logic [REG_W-1:0]  ID_rs,
    input  logic [REG_W-1:0]  ID_rt,
    input  logic [DATA_W-1:0] MEM_ReadData,
    output logic [DATA_W-1:0] MEM_ALUResult,
    output logic [REG_W-1:0]  MEM_rDestSelected,
    output logic              MEM_MemRead,
    output logic              MEM_MemWrite,
    output logic [DATA_W-1:0] MEM_StoreData,
    output logic [REG_W-1:0]  WB_rDestSelected,
    output logic              WB_RegWrite,
    output logic [DATA_W-1:0] WB_regWriteData,
    output logic              Stall,
    output logic [CNT_W-1:0]  StallCount
);

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrl_t             mem_ctrl_q, mem_ctrl_d;
    logic [DATA_W-1:0] mem_alu_q, mem_alu_d;
    logic [REG_W-1:0]  mem_dest_q, mem_dest_d;
    logic [DATA_W-1:0] mem_store_q, mem_store_d;

    ctrl_t             wb_ctrl_q, wb_ctrl_d;
    logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
    logic [REG_W-1:0]  wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0] wb_rdata_q, wb_rdata_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_c;
    logic              ex_hits_id_c;

    // Load-use hazard: a flushed load never completes, so it cannot stall.
    always_comb begin
        ex_hits_id_c = (EX_rDestSelected == ID_rs) || (EX_rDestSelected == ID_rt);
        stall_c      = !Rst && !Flush && EX_MemRead && EX_RegWrite &&
                       (EX_rDestSelected != '0) && ex_hits_id_c;
    end

    // Next-state for both pipeline registers and the stall counter.
    always_comb begin
        mem_ctrl_d            = '0;
        mem_ctrl_d.reg_write  = EX_RegWrite;
        mem_ctrl_d.mem_read   = EX_MemRead;
        mem_ctrl_d.mem_write  = EX_MemWrite;
        mem_ctrl_d.mem_to_reg = EX_MemToReg;
        if (Flush) begin
            mem_ctrl_d = '0;
        end
        mem_alu_d   = EX_ALUResult;
        mem_dest_d  = EX_rDestSelected;
        mem_store_d = EX_StoreData;

        wb_ctrl_d  = mem_ctrl_q;
        wb_alu_d   = mem_alu_q;
        wb_dest_d  = mem_dest_q;
        wb_rdata_d = MEM_ReadData;

        cnt_d = cnt_q;
        if (stall_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mem_ctrl_q  <= '0;
            mem_alu_q   <= '0;
            mem_dest_q  <= '0;
            mem_store_q <= '0;
            wb_ctrl_q   <= '0;
            wb_alu_q    <= '0;
            wb_dest_q   <= '0;
            wb_rdata_q  <= '0;
            cnt_q       <= '0;
        end else begin
            mem_ctrl_q  <= mem_ctrl_d;
            mem_alu_q   <= mem_alu_d;
            mem_dest_q  <= mem_dest_d;
            mem_store_q <= mem_store_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_alu_q    <= wb_alu_d;
            wb_dest_q   <= wb_dest_d;
            wb_rdata_q  <= wb_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Destinations are zeroed for non-writers and $0 so forwarding never matches them.
    always_comb begin
        MEM_ALUResult     = mem_alu_q;
        MEM_rDestSelected = (mem_ctrl_q.reg_write && (mem_dest_q != '0)) ? mem_dest_q : '0;
        MEM_MemRead       = mem_ctrl_q.mem_read;
        MEM_MemWrite      = mem_ctrl_q.mem_write;
        MEM_StoreData     = mem_store_q;
        WB_RegWrite       = wb_ctrl_q.reg_write && (wb_dest_q != '0);
        WB_rDestSelected  = WB_RegWrite ? wb_dest_q : '0;
        WB_regWriteData   = wb_ctrl_q.mem_to_reg ? wb_rdata_q : wb_alu_q;
        Stall             = stall_c;
        StallCount        = cnt_q;
    end

endmodule

// File: tb/tb_ex_mem_wb_forward_source.sv
// Directed bench for ex_mem_wb_forward_source; counter width reduced to 4 to reach saturation.
module tb_ex_mem_wb_forward_source;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 4;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Flush;
    logic [DATA_W-1:0] EX_ALUResult;
    logic [REG_W-1:0]  EX_rDestSelected;
    logic              EX_RegWrite;
    logic              EX_MemRead;
    logic              EX_MemWrite;
    logic              EX_MemToReg;
    logic [DATA_W-1:0] EX_StoreData;
    logic [REG_W-1:0]  ID_rs;
    logic [REG_W-1:0]  ID_rt;
    logic [DATA_W-1:0] MEM_ReadData;
    logic [DATA_W-1:0] MEM_ALUResult;
    logic [REG_W-1:0]  MEM_rDestSelected;
    logic              MEM_MemRead;
    logic              MEM_MemWrite;
    logic [DATA_W-1:0] MEM_StoreData;
    logic [REG_W-1:0]  WB_rDestSelected;
    logic              WB_RegWrite;
    logic [DATA_W-1:0] WB_regWriteData;
    logic              Stall;
    logic [CNT_W-1:0]  StallCount;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    ex_mem_wb_forward_source #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush),
        .EX_ALUResult(EX_ALUResult), .EX_rDestSelected(EX_rDestSelected),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_MemToReg(EX_MemToReg), .EX_StoreData(EX_StoreData),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .MEM_ReadData(MEM_ReadData),
        .MEM_ALUResult(MEM_ALUResult), .MEM_rDestSelected(MEM_rDestSelected),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_StoreData(MEM_StoreData),
        .WB_rDestSelected(WB_rDestSelected), .WB_RegWrite(WB_RegWrite),
        .WB_regWriteData(WB_regWriteData), .Stall(Stall), .StallCount(StallCount)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_idle();
        Flush = 1'b0; EX_ALUResult = '0; EX_rDestSelected = '0; EX_RegWrite = 1'b0;
        EX_MemRead = 1'b0; EX_MemWrite = 1'b0; EX_MemToReg = 1'b0; EX_StoreData = '0;
        ID_rs = '0; ID_rt = '0;
    endtask

    task automatic set_load(input logic [REG_W-1:0] dest);
        set_idle();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_MemToReg = 1'b1;
        EX_rDestSelected = dest; EX_ALUResult = 32'h0000_0100;
    endtask

    task automatic test_reset();
        Rst = 1'b1; MEM_ReadData = 32'h1111_2222;
        set_load(5'd5);
        ID_rs = 5'd5; EX_MemWrite = 1'b1; EX_StoreData = 32'hABCD_0123;
        tick();
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", Stall); end
        tick();
        checks++; if (MEM_ALUResult !== '0) begin errors++; $display("FAIL reset_mem_alu: got %h expected 0", MEM_ALUResult); end
        checks++; if (MEM_rDestSelected !== '0) begin errors++; $display("FAIL reset_mem_dest: got %0d expected 0", MEM_rDestSelected); end
        checks++; if (MEM_MemRead !== 1'b0 || MEM_MemWrite !== 1'b0) begin errors++; $display("FAIL reset_mem_strobes: got %b%b expected 00", MEM_MemRead, MEM_MemWrite); end
        checks++; if (MEM_StoreData !== '0) begin errors++; $display("FAIL reset_store: got %h expected 0", MEM_StoreData); end
        checks++; if (WB_rDestSelected !== '0 || WB_RegWrite !== 1'b0) begin errors++; $display("FAIL reset_wb_dest: got %0d/%b expected 0/0", WB_rDestSelected, WB_RegWrite); end
        checks++; if (WB_regWriteData !== '0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", WB_regWriteData); end
        checks++; if (StallCount !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", StallCount); end
        set_idle();
        Rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_alu_forward();
        set_idle();
        EX_ALUResult = 32'h0000_1234; EX_rDestSelected = 5'd8; EX_RegWrite = 1'b1;
        tick();
        set_idle();
        checks++; if (MEM_ALUResult !== 32'h0000_1234) begin errors++; $display("FAIL alu_mem_result: got %h expected 00001234", MEM_ALUResult); end
        checks++; if (MEM_rDestSelected !== 5'd8) begin errors++; $display("FAIL alu_mem_dest: got %0d expected 8", MEM_rDestSelected); end
        tick();
        checks++; if (WB_rDestSelected !== 5'd8 || WB_RegWrite !== 1'b1) begin errors++; $display("FAIL alu_wb_dest: got %0d/%b expected 8/1", WB_rDestSelected, WB_RegWrite); end
        checks++; if (WB_regWriteData !== 32'h0000_1234) begin errors++; $display("FAIL alu_wb_data: got %h expected 00001234", WB_regWriteData); end
        checks++; if (MEM_rDestSelected !== '0) begin errors++; $display("FAIL alu_mem_bubble: got %0d expected 0", MEM_rDestSelected); end
    endtask

    task automatic test_load_use();
        set_load(5'd9);
        ID_rs = 5'd3; ID_rt = 5'd9;
        #1;
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL lu_stall_rt: got %b expected 1", Stall); end
        tick();
        exp_cnt = 1;
        set_idle();
        MEM_ReadData = 32'hCAFE_F00D;
        checks++; if (StallCount !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL lu_count: got %0d expected %0d", StallCount, exp_cnt); end
        checks++; if (MEM_MemRead !== 1'b1 || MEM_rDestSelected !== 5'd9) begin errors++; $display("FAIL lu_mem: got %b/%0d expected 1/9", MEM_MemRead, MEM_rDestSelected); end
        tick();
        MEM_ReadData = 32'h0BAD_0BAD;
        checks++; if (WB_regWriteData !== 32'hCAFE_F00D) begin errors++; $display("FAIL lu_wb_data: got %h expected cafef00d", WB_regWriteData); end
        checks++; if (WB_rDestSelected !== 5'd9 || WB_RegWrite !== 1'b1) begin errors++; $display("FAIL lu_wb_dest: got %0d/%b expected 9/1", WB_rDestSelected, WB_RegWrite); end
        set_load(5'd9);
        ID_rs = 5'd10; ID_rt = 5'd10;
        #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL lu_nodep: got %b expected 0", Stall); end
        tick();
        set_load(5'd11);
        ID_rs = 5'd11; ID_rt = 5'd2;
        #1;
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL lu_stall_rs: got %b expected 1", Stall); end
        tick();
        exp_cnt = 2;
        checks++; if (StallCount !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL lu_count2: got %0d expected %0d", StallCount, exp_cnt); end
        set_load(5'd11);
        EX_RegWrite = 1'b0; ID_rs = 5'd11;
        #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL lu_noregwrite: got %b expected 0", Stall); end
        tick();
    endtask

    task automatic test_flush();
        set_idle();
        EX_ALUResult = 32'h0000_55AA; EX_rDestSelected = 5'd12; EX_RegWrite = 1'b1;
        tick();
        set_load(5'd9);
        ID_rs = 5'd9; Flush = 1'b1; EX_ALUResult = 32'h0000_0777;
        #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", Stall); end
        tick();
        set_idle();
        checks++; if (MEM_MemRead !== 1'b0 || MEM_rDestSelected !== '0) begin errors++; $display("FAIL flush_mem: got %b/%0d expected 0/0", MEM_MemRead, MEM_rDestSelected); end
        checks++; if (WB_rDestSelected !== 5'd12 || WB_regWriteData !== 32'h0000_55AA) begin errors++; $display("FAIL flush_wb: got %0d/%h expected 12/000055aa", WB_rDestSelected, WB_regWriteData); end
        checks++; if (StallCount !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL flush_count: got %0d expected %0d", StallCount, exp_cnt); end
        tick();
        checks++; if (WB_RegWrite !== 1'b0) begin errors++; $display("FAIL flush_wb_bubble: got %b expected 0", WB_RegWrite); end
    endtask

    task automatic test_zero_dest();
        set_idle();
        EX_ALUResult = 32'h0000_FFFF; EX_RegWrite = 1'b1;
        tick();
        set_idle();
        checks++; if (MEM_rDestSelected !== '0 || MEM_ALUResult !== 32'h0000_FFFF) begin errors++; $display("FAIL zero_mem: got %0d/%h expected 0/0000ffff", MEM_rDestSelected, MEM_ALUResult); end
        tick();
        checks++; if (WB_RegWrite !== 1'b0 || WB_rDestSelected !== '0) begin errors++; $display("FAIL zero_wb: got %b/%0d expected 0/0", WB_RegWrite, WB_rDestSelected); end
        set_load(5'd0);
        ID_rs = 5'd0;
        #1;
        checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b expected 0", Stall); end
        tick();
    endtask

    task automatic test_store();
        set_idle();
        EX_MemWrite = 1'b1; EX_ALUResult = 32'h0000_0040; EX_StoreData = 32'hDEAD_BEEF;
        EX_rDestSelected = 5'd7;
        tick();
        set_idle();
        checks++; if (MEM_MemWrite !== 1'b1 || MEM_StoreData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_mem: got %b/%h expected 1/deadbeef", MEM_MemWrite, MEM_StoreData); end
        checks++; if (MEM_rDestSelected !== '0) begin errors++; $display("FAIL store_dest: got %0d expected 0", MEM_rDestSelected); end
    endtask

    task automatic test_saturation();
        set_load(5'd7);
        ID_rs = 5'd7;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (exp_cnt < 15) exp_cnt++;
            checks++; if (StallCount !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, StallCount, exp_cnt); end
        end
        checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b expected 1", Stall); end
        Rst = 1'b1;
        tick();
        exp_cnt = 0;
        checks++; if (StallCount !== '0) begin errors++; $display("FAIL sat_reset: got %0d expected 0", StallCount); end
        Rst = 1'b0;
        set_idle();
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_flush();
        test_zero_dest();
        test_store();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_wb_forward_source.md
Name: ex_mem_wb_forward_source

Overview:
- Producer end of the operand-forwarding interface that Execute consumes.
- Holds the EX/MEM and MEM/WB pipeline registers and drives MEM_ALUResult, MEM_rDestSelected, WB_rDestSelected and WB_regWriteData back to Execute.
- Detects load-use hazards, raises Stall toward IF/ID, and counts stall cycles.
- Sits between Execute, data memory and the register-file write port.

Parameters:
DATA_W, 32, datapath width
REG_W, 5, register address width
CNT_W, 16, stall counter width

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  synchronous reset, active-high
Flush  in  1  convert the instruction currently in EX into a bubble at this edge
EX_ALUResult  in  DATA_W  ALU result from Execute
EX_rDestSelected  in  REG_W  destination register from Execute
EX_RegWrite  in  1  EX instruction writes the register file
EX_MemRead  in  1  EX instruction is a load
EX_MemWrite  in  1  EX instruction is a store
EX_MemToReg  in  1  writeback selects memory data
EX_StoreData  in  DATA_W  store data (forwarded rt value)
ID_rs  in  REG_W  rs of the instruction in ID
ID_rt  in  REG_W  rt of the instruction in ID
MEM_ReadData  in  DATA_W  combinational data-memory read data for the MEM-stage address
MEM_ALUResult  out  DATA_W  registered EX/MEM ALU result (memory address / forward value)
MEM_rDestSelected  out  REG_W  EX/MEM destination, qualified
MEM_MemRead  out  1  load strobe to data memory
MEM_MemWrite  out  1  store strobe to data memory
MEM_StoreData  out  DATA_W  store data to data memory
WB_rDestSelected  out  REG_W  MEM/WB destination, qualified
WB_RegWrite  out  1  register-file write enable
WB_regWriteData  out  DATA_W  register-file write data / forward value
Stall  out  1  hold PC and IF/ID; zero ID/EX controls
StallCount  out  CNT_W  saturating count of stall cycles

Behaviour:
- **Clock and reset.** Single clock Clk. Reset Rst is synchronous and active-high, and takes priority over all other inputs.
- **Reset values.** On reset every register clears to 0, so all outputs read 0. Stall is combinational and also reads 0, because the qualified inputs are irrelevant while Rst is asserted.
- **EX/MEM register, per edge:**
  - Captures all EX_* inputs.
  - If Flush=1, the control bits (RegWrite, MemRead, MemWrite, MemToReg) load 0. Data fields still load and are don't-care.
  - Stall does not gate this register; the load advances into MEM.
- **MEM/WB register, per edge:**
  - Captures the EX/MEM controls, ALU result and destination.
  - Captures MEM_ReadData into an internal read-data register.
  - Flush does not affect MEM/WB.
- **Latency.**
  - EX inputs appear on MEM_* outputs 1 cycle later.
  - The same instruction appears on WB_* outputs 2 cycles later.
- **Writeback data.** WB_regWriteData = WB MemToReg ? registered read data : WB ALU result. This is combinational from registers.
- **Destination qualification.**
  - MEM_rDestSelected = (MEM RegWrite && dest != 0) ? dest : 0.
  - WB_rDestSelected and WB_RegWrite follow the same rule.
  - Writes to $0 are suppressed: WB_RegWrite=0 and WB_rDestSelected=0.
  - Consequently the forwarding unit never matches a non-writing instruction or $0.
- **Stall (combinational).**
  - Stall = EX_MemRead && EX_RegWrite && EX_rDestSelected != 0 && (EX_rDestSelected == ID_rs || EX_rDestSelected == ID_rt).
  - Stall is forced to 0 when Flush=1, since the flushed load never completes.
  - One stall cycle suffices: the load is in WB when the dependent instruction reaches EX, and the value comes from WB_regWriteData.
- **StallCount.** Increments by 1 on each edge where Stall=1 and Rst=0. It saturates at all-ones and does not wrap.
- **Simultaneous events.**
  - Flush and Stall in the same cycle: Flush wins.
  - Rst with anything else: reset wins.

Test Plan:
1. **Reset.** Drive arbitrary inputs with Rst=1 for 2 cycles → every output = 0, Stall = 0, StallCount = 0.
2. **ALU forward path.** EX: ALUResult=0x1234, dest=8, RegWrite=1 → next cycle MEM_ALUResult=0x1234, MEM_rDestSelected=8. Following cycle WB_rDestSelected=8, WB_RegWrite=1, WB_regWriteData=0x1234.
3. **Load-use stall.**
   - EX: MemRead=1, RegWrite=1, MemToReg=1, dest=9; ID_rt=9 → Stall=1 in that cycle and StallCount=1 after the edge.
   - With MEM_ReadData=0xCAFEF00D in the MEM cycle → WB_regWriteData=0xCAFEF00D, WB_rDestSelected=9 one cycle later.
   - Repeat with ID_rs=ID_rt=10 → Stall=0.
4. **Flush.** EX: load to dest=9, ID_rs=9, Flush=1 → Stall=0. Next cycle MEM_MemRead=0 and MEM_rDestSelected=0. WB stage still completes the prior instruction unchanged.
5. **$0 suppression.** EX: RegWrite=1, dest=0, ALUResult=0xFFFF → MEM_rDestSelected=0, WB_RegWrite=0. Load to dest=0 with ID_rs=0 → Stall=0.
6. **Counter saturation.** With CNT_W=4, hold stall conditions for 20 cycles → StallCount reaches 15 and stays at 15.
